muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal values 8..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, operation request; sampled only when the FSM is IDLE.
REQ-005 SHALL have port op, input, 2, operation select: 00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div; sampled with start.
REQ-006 SHALL have port a, input, WIDTH, multiplicand or dividend; sampled with start.
REQ-007 SHALL have port b, input, WIDTH, multiplier or divisor; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress (CALC or ADJ).
REQ-009 SHALL have port done, output, 1, registered one-cycle completion pulse.
REQ-010 SHALL have port div_zero, output, 1, registered pulse coincident with done when a divide had b == 0.
REQ-011 SHALL have ports hi and lo, output, WIDTH each, result registers.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and ADJ.
REQ-013 IDLE: on start=1, SHALL latch op, |a| and |b| (magnitudes for signed ops), record the result signs, go to CALC, and load the iteration counter with WIDTH.
REQ-014 SHALL go directly from IDLE to ADJ, skipping CALC, when a divide is started with b == 0.
REQ-015 CALC SHALL perform one radix-2 step per cycle (shift-add for mult, restoring shift-subtract for div), decrement the counter, and go to ADJ when the counter reaches 0.
REQ-016 ADJ SHALL apply the sign correction, write hi/lo, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle after WIDTH+2 rising edges counted from the edge that samples start; for divide-by-zero it SHALL be high after 2 edges.
REQ-018 Mult: {hi,lo} SHALL equal the full 2*WIDTH-bit product, two's complement for op 00.
REQ-019 Div: lo SHALL be the quotient and hi the remainder; for signed division the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Signed div of most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no flag.
REQ-021 Divide by zero SHALL leave hi and lo unchanged and pulse div_zero together with done.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 start in the cycle done=1 SHALL be accepted, since the FSM is already IDLE (back-to-back operation).
REQ-024 hi and lo SHALL hold their values between completions; a, b and op MAY change freely after the start cycle.

Reset
REQ-025 Asserting reset at any time SHALL force IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, and counter=0.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse; the first start after deassertion SHALL operate normally.

Configuration
REQ-027 With macro MULDIV_EARLY_OUT_EN defined, multiply CALC SHALL exit once the remaining unprocessed multiplier magnitude bits are all zero, using max(1, index of highest set bit of |b| + 1) iterations; results SHALL be identical to the non-early-out case.
REQ-028 Without MULDIV_EARLY_OUT_EN, every non-zero-divisor operation SHALL take exactly WIDTH CALC cycles; divide latency SHALL be unaffected by the macro in both builds.

Verification (WIDTH=32)
REQ-029 op=00, a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB, done after 34 edges (macro off).
REQ-030 op=01, a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; a second start in the done cycle with op=01, a=2, b=3 -> hi=0, lo=6.
REQ-031 op=10, a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; op=10, a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-032 op=11, a=00000064, b=0 with hi/lo holding prior values -> done and div_zero both high after 2 edges, hi/lo unchanged.
REQ-033 Start a mult, pulse start again at edge 5 (ignored), assert reset at edge 10 -> busy=0, hi=lo=0, no done; a new start then completes correctly.
REQ-034 Macro on, op=01, a=00000005, b=00000003 -> hi=0, lo=0000000F, done after 4 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide, sign fix-up in ADJ.
// Optional macro MULDIV_EARLY_OUT_EN lets multiply stop once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, ADJ} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CW-1:0]      r_count;
  logic               r_isDiv;
  logic               r_divZero;
  logic               r_negQ;
  logic               r_negR;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_opB;

  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic               w_startDivZero;
  logic               w_lastStep;
  logic               w_inAdj;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_divAcc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // op[0]=0 selects the signed flavour for both multiply and divide
  assign w_aNeg         = ~op[0] & a[WIDTH-1];
  assign w_bNeg         = ~op[0] & b[WIDTH-1];
  assign w_aMag         = w_aNeg ? (~a + 1'b1) : a;
  assign w_bMag         = w_bNeg ? (~b + 1'b1) : b;
  assign w_startDivZero = op[1] & (b == '0);

  // Restoring step: the high half of r_acc is the partial remainder, the low half shifts dividend out and quotient in
  assign w_shift  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_opB});
  assign w_diff   = w_shift[WIDTH-1:0] - r_opB;
  assign w_divAcc = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                         : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod = r_negQ ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_negQ ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_negR ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  assign w_lastStep = (r_count == CW'(1)) || (!r_isDiv && (r_opB[WIDTH-1:1] == '0));
`else
  assign w_lastStep = (r_count == CW'(1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = w_startDivZero ? ADJ : CALC;
      CALC:    if (w_lastStep) w_nextState = ADJ;
      ADJ:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != IDLE);
    w_inAdj = (r_state == ADJ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_divZero <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_opB     <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done     <= w_inAdj;
      div_zero <= w_inAdj & r_divZero;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_isDiv   <= op[1];
            r_divZero <= w_startDivZero;
            r_negQ    <= w_aNeg ^ w_bNeg;
            r_negR    <= w_aNeg;
            r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_aMag} : '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_aMag};
            r_opB     <= w_bMag;
            r_count   <= CW'(WIDTH);
          end
        end
        CALC: begin
          r_count <= r_count - 1'b1;
          if (r_isDiv) begin
            r_acc <= w_divAcc;
          end else begin
            r_acc   <= r_acc + (r_opB[0] ? r_mcand : '0);
            r_mcand <= r_mcand << 1;
            r_opB   <= r_opB >> 1;
          end
        end
        ADJ: begin
          r_count <= '0;
          if (!r_divZero) begin
            if (r_isDiv) begin
              hi <= w_rem;
              lo <= w_quo;
            end else begin
              hi <= w_prod[2*WIDTH-1:WIDTH];
              lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32: directed vector table plus hand-written
// sequences for back-to-back start, start-while-busy and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
  } vector_t;

  vector_t vectors[14];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against the bench's expectation and tally it
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Expected edge count from the sampling edge to the done cycle
  function automatic int expEdges(input logic [1:0] opSel, input logic [31:0] bVal);
    logic [31:0] mag;
    int iters;
    if (opSel[1] && bVal == 32'd0) return 2;
    if (opSel[1]) return 34;
    mag = (!opSel[0] && bVal[31]) ? (~bVal + 32'd1) : bVal;
    iters = 32;
`ifdef MULDIV_EARLY_OUT_EN
    iters = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) iters = i + 1;
`endif
    if (mag == 32'hFFFF_FFFF) iters = 32;
    return iters + 2;
  endfunction

  // Wait (bounded) for done; edges counts the start-sampling edge as edge 1
  task automatic waitDone(output int edges);
    edges = 1;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Drive one request at the negedge, let the next posedge sample it, then wait for done
  task automatic applyStimulus(input logic [1:0] opSel, input logic [31:0] aVal,
                               input logic [31:0] bVal, output int edges);
    @(negedge clk);
    start = 1'b1;
    op    = opSel;
    a     = aVal;
    b     = bVal;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0BAD_F00D;
    waitDone(edges);
  endtask

  initial begin
    int edges;
    logic sawDone;

    vectors[0]  = '{"smul -3*7",          2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vectors[1]  = '{"umul max*max",       2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vectors[2]  = '{"sdiv -7/2",          2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vectors[3]  = '{"sdiv minneg/-1",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vectors[4]  = '{"udiv 100/7",         2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vectors[5]  = '{"sdiv 7/-2",          2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vectors[6]  = '{"smul minneg^2",      2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vectors[7]  = '{"smul -1*1",          2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vectors[8]  = '{"udiv by zero",       2'b11, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vectors[9]  = '{"umul 5*3",           2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F, 1'b0};
    vectors[10] = '{"sdiv by zero",       2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 32'h0000_0000, 32'h0000_000F, 1'b1};
    vectors[11] = '{"umul by zero",       2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vectors[12] = '{"udiv max/1",         2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vectors[13] = '{"sdiv -100/7",        2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy",     64'(busy),     64'd0);
    checkOutput("reset done",     64'(done),     64'd0);
    checkOutput("reset div_zero", 64'(div_zero), 64'd0);
    checkOutput("reset hi",       64'(hi),       64'd0);
    checkOutput("reset lo",       64'(lo),       64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, edges);
      checkOutput({vectors[i].name, " latency"},  64'(edges),    64'(expEdges(vectors[i].op, vectors[i].b)));
      checkOutput({vectors[i].name, " hi"},       64'(hi),       64'(vectors[i].expHi));
      checkOutput({vectors[i].name, " lo"},       64'(lo),       64'(vectors[i].expLo));
      checkOutput({vectors[i].name, " div_zero"}, 64'(div_zero), 64'(vectors[i].expDz));
      @(posedge clk);
      #1;
      checkOutput({vectors[i].name, " done width"}, 64'(done), 64'd0);
    end

    // Back-to-back: a new start in the done cycle is accepted
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges);
    checkOutput("b2b first hi", 64'(hi), 64'hFFFF_FFFE);
    checkOutput("b2b first lo", 64'(lo), 64'h0000_0001);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd2;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(edges);
    checkOutput("b2b second latency", 64'(edges), 64'(expEdges(2'b01, 32'd3)));
    checkOutput("b2b second hi",      64'(hi),    64'h0);
    checkOutput("b2b second lo",      64'(lo),    64'h6);

    // Start pulsed while busy must not disturb the running multiply
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd6;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignored start busy", 64'(busy), 64'd1);
    edges = 5;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("ignored start latency",  64'(edges),    64'(expEdges(2'b01, 32'd7)));
    checkOutput("ignored start hi",       64'(hi),       64'h0);
    checkOutput("ignored start lo",       64'(lo),       64'd42);
    checkOutput("ignored start div_zero", 64'(div_zero), 64'd0);

    // Reset in the middle of a multiply aborts it with no done pulse
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'hFFFF_FFFD;
    b     = 32'hFFFF_FFF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid reset busy", 64'(busy), 64'd0);
    checkOutput("mid reset done", 64'(done), 64'd0);
    checkOutput("mid reset hi",   64'(hi),   64'd0);
    checkOutput("mid reset lo",   64'(lo),   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("no activity after reset", 64'(sawDone), 64'd0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFF0, edges);
    checkOutput("post reset latency", 64'(edges), 64'(expEdges(2'b00, 32'hFFFF_FFF0)));
    checkOutput("post reset hi",      64'(hi),    64'h0);
    checkOutput("post reset lo",      64'(lo),    64'd48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
